// File: rtl/gabor_win_pkg.sv
// Shared window geometry for the 5x5 window streamer and the Gabor convolution bank.
// Used by window_5x5_streamer (optional SOF_CHECK_EN feature lives in the top).
package gabor_win_pkg;
   localparam int WIN     = 5;
   localparam int WIN_PIX = 25;

   typedef logic [WIN_PIX-1:0] win_t;

   function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
      return r * WIN + c;
   endfunction
endpackage

// File: rtl/line_buffer.sv
// One row of 1-bit pixels: registered write, combinational read, addressed by column.
// Contents are deliberately not reset. Part of window_5x5_streamer (see SOF_CHECK_EN there).
module line_buffer #(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic                     din,
   output logic                     dout
);
   logic [DEPTH-1:0] mem;

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= din;
   end

   assign dout = mem[addr];
endmodule

// File: rtl/window_5x5_streamer.sv
// Raster 1-bit pixel stream -> one 5x5 window per accepted pixel once a full window exists.
// Define SOF_CHECK_EN to add the s_sof input and sticky err_sof output with frame resync.
module window_5x5_streamer
   import gabor_win_pkg::*;
#(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic       s_pixel,
`ifdef SOF_CHECK_EN
   input  logic       s_sof,
   output logic       err_sof,
`endif
   output logic       m_valid,
   input  logic       m_ready,
   output win_t       m_win,
   output logic       m_last
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0] col, cur_col;
   logic [RW-1:0] row, cur_row;
   logic          accept, sof_resync, emit, last_pix;
   logic [3:0]    lb_d, lb_q;
   win_t          win, win_next;

   assign s_ready = !m_valid || m_ready;
   assign accept  = s_valid && s_ready;

   // A misplaced start-of-frame makes this pixel (0,0) for addressing, emission and counting.
   always_comb begin
      sof_resync = 1'b0;
`ifdef SOF_CHECK_EN
      sof_resync = s_sof && ((row != '0) || (col != '0));
`endif
      cur_col  = sof_resync ? '0 : col;
      cur_row  = sof_resync ? '0 : row;
      emit     = (int'(cur_row) >= 4) && (int'(cur_col) >= 4);
      last_pix = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
   end

   always_comb begin
      lb_d[0] = s_pixel;
      for (int unsigned i = 1; i < 4; i++) lb_d[i] = lb_q[i-1];
   end

   for (genvar g = 0; g < 4; g++) begin : g_lb
      line_buffer #(.DEPTH(IMG_W)) u_lb (
         .clk  (clk),
         .we   (accept),
         .addr (cur_col),
         .din  (lb_d[g]),
         .dout (lb_q[g])
      );
   end

   // Shift left one column; new right column top->bottom is lb3, lb2, lb1, lb0, s_pixel.
   always_comb begin
      win_next = '0;
      for (int unsigned r = 0; r < WIN; r++) begin
         for (int unsigned c = 0; c < WIN - 1; c++) begin
            win_next[win_idx(r, c)] = win[win_idx(r, c + 1)];
         end
      end
      for (int unsigned r = 0; r < WIN - 1; r++) begin
         win_next[win_idx(r, WIN - 1)] = lb_q[3 - r];
      end
      win_next[win_idx(WIN - 1, WIN - 1)] = s_pixel;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col     <= '0;
         row     <= '0;
         win     <= '0;
         m_valid <= 1'b0;
         m_win   <= '0;
         m_last  <= 1'b0;
      end else begin
         if (accept) begin
            win <= win_next;
            if (cur_col == CW'(IMG_W - 1)) begin
               col <= '0;
               row <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
            end else begin
               col <= cur_col + 1'b1;
               row <= cur_row;
            end
         end
         if (accept && emit) begin
            m_valid <= 1'b1;
            m_win   <= win_next;
            m_last  <= last_pix;
         end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end
      end
   end

`ifdef SOF_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst)                      err_sof <= 1'b0;
      else if (accept && sof_resync) err_sof <= 1'b1;
   end
`endif
endmodule

// File: tb/tb_window_5x5_streamer.sv
// Directed bench for window_5x5_streamer on an 8x8 image with an independent window model.
// Define SOF_CHECK_EN to also exercise the start-of-frame resync path.
module tb_window_5x5_streamer;
   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic        s_ready;
   logic        s_pixel;
   logic        s_sof;
   logic        err_sof;
   logic        m_valid;
   logic        m_ready;
   logic [24:0] m_win;
   logic        m_last;

   int checks = 0;
   int errors = 0;

   logic img [8][8];
   int   mr = 0, mc = 0;
   int   nwin = 0, nlast = 0;
   bit   seen_win = 0;
   logic [24:0] last_exp;

   always #5 clk = ~clk;

   window_5x5_streamer #(.IMG_W(8), .IMG_H(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_pixel (s_pixel),
`ifdef SOF_CHECK_EN
      .s_sof   (s_sof),
      .err_sof (err_sof),
`endif
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_win   (m_win),
      .m_last  (m_last)
   );

`ifndef SOF_CHECK_EN
   assign err_sof = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic pat(input int kind, input int r, input int c);
      case (kind)
         0:       return ((r * 8 + c) % 3) == 0;
         1:       return c >= 5;
         2:       return ((r * 3 + c * 5) % 7) < 3;
         default: return ((r ^ c) & 1) == 1;
      endcase
   endfunction

   // Window bit i*5+j is image pixel (r-4+i, c-4+j).
   function automatic logic [24:0] exp_win(input int r, input int c);
      logic [24:0] w;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            w[i * 5 + j] = img[r - 4 + i][c - 4 + j];
      return w;
   endfunction

   task automatic send(input int kind, input logic sof);
      logic p;
      bit   em;
      p = pat(kind, mr, mc);
      img[mr][mc] = p;
      if (mr == 0 && mc == 0) seen_win = 0;
      s_valid = 1'b1;
      s_pixel = p;
      s_sof   = sof;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_sof   = 1'b0;
      em = (mr >= 4) && (mc >= 4);
      check("m_valid", {31'd0, m_valid}, {31'd0, em});
      if (em) begin
         last_exp = exp_win(mr, mc);
         check("m_win", {7'd0, m_win}, {7'd0, last_exp});
         check("m_last", {31'd0, m_last}, {31'd0, (mr == 7 && mc == 7)});
         if (kind == 1 && mc == 4) check("no_straddle", {7'd0, m_win}, 32'd0);
         if (!seen_win) check("first_win_idx", mr * 8 + mc, 36);
         seen_win = 1;
         nwin++;
         if (m_last) nlast++;
      end
      if (mc == 7) begin
         mc = 0;
         mr = (mr == 7) ? 0 : mr + 1;
      end else begin
         mc++;
      end
   endtask

   task automatic run(input int kind, input int n);
      for (int k = 0; k < n; k++) send(kind, 1'b0);
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_pixel = 1'b0; s_sof = 1'b0; m_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_m_valid", {31'd0, m_valid}, 32'd0);
      check("rst_m_win", {7'd0, m_win}, 32'd0);
      check("rst_m_last", {31'd0, m_last}, 32'd0);
      check("rst_s_ready", {31'd0, s_ready}, 32'd1);

      // Two back-to-back frames: modulo-3 pattern then right-side-only pattern.
      run(0, 64);
      check("frame_a_wins", nwin, 16);
      check("frame_a_last", nlast, 1);
      run(1, 64);
      check("two_frame_wins", nwin, 32);
      check("two_frame_lasts", nlast, 2);

      // Backpressure on a held window at (5,5).
      nwin = 0; nlast = 0;
      run(2, 5 * 8 + 6);
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_pixel = pat(2, mr, mc);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check("bp_s_ready", {31'd0, s_ready}, 32'd0);
         check("bp_m_valid", {31'd0, m_valid}, 32'd1);
         check("bp_m_win", {7'd0, m_win}, {7'd0, last_exp});
         check("bp_m_last", {31'd0, m_last}, 32'd0);
      end
      m_ready = 1'b1;
      run(2, 64 - (5 * 8 + 6));
      check("bp_frame_wins", nwin, 16);
      check("bp_frame_last", nlast, 1);

      // Reset mid-frame with a window pending.
      run(3, 5 * 8 + 6);
      m_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_ready = 1'b1;
      check("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
      check("mid_rst_m_win", {7'd0, m_win}, 32'd0);
      mr = 0; mc = 0; nwin = 0; nlast = 0;
      run(3, 64);
      check("post_rst_wins", nwin, 16);
      check("post_rst_last", nlast, 1);

`ifdef SOF_CHECK_EN
      send(0, 1'b1);
      check("sof_legal", {31'd0, err_sof}, 32'd0);
      run(0, 19);
      mr = 0; mc = 0;
      send(0, 1'b1);
      check("err_sof_set", {31'd0, err_sof}, 32'd1);
      nwin = 0;
      run(0, 35);
      check("sof_no_early_win", nwin, 0);
      run(0, 1);
      check("sof_win_after_36", nwin, 1);
      run(0, 27);
      check("err_sof_sticky", {31'd0, err_sof}, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
